// File: rtl/alarm_pio_defs_pkg.sv
// Shared definitions for the alarm clock output PIO: register offsets,
// CTRL bit positions and the pulse timer state encoding.
package alarm_pio_defs;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PMASK    = 3'd1;
    localparam logic [2:0] ADDR_PLEN     = 3'd2;
    localparam logic [2:0] ADDR_CTRL     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    // Write-side and read-side CTRL bits share positions 0/1 with different meanings
    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_DONE_CLR = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_BUSY     = 0;
    localparam int CTRL_DONE     = 1;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/system_alarm_pulse_timer.sv
// One-shot pulse timer: holds the IDLE/PULSE FSM and the down-counter,
// flagging completion with a single-cycle done pulse.
module system_alarm_pulse_timer
    import alarm_pio_defs::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_pulse_o
);

    pulse_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PULSE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Abort beats start, and a start (retrigger) beats the natural completion;
    // a zero length start is dropped so the counter can never wrap.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_pulse_o = 1'b0;
        if (abort_i) begin
            state_d = PULSE_IDLE;
            cnt_d   = '0;
        end else if (start_i && (len_i != '0)) begin
            state_d = PULSE_ACTIVE;
            cnt_d   = len_i;
        end else if (state_q == PULSE_ACTIVE) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d      = PULSE_IDLE;
                cnt_d        = '0;
                done_pulse_o = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign busy_o = (state_q == PULSE_ACTIVE);

endmodule

// File: rtl/system_alarm_pulse_pio.sv
// Avalon-MM output PIO for the alarm clock: data register with atomic
// set/clear, plus a one-shot timer that ORs PMASK onto out_port.
module system_alarm_pulse_pio
    import alarm_pio_defs::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] pulseMask_q, pulseMask_d;
    logic [CNT_W-1:0] pulseLen_q, pulseLen_d;
    logic             irqEn_q, irqEn_d;
    logic             done_q, done_d;
    logic [31:0]      readData_q, readData_d;
    logic [WIDTH-1:0] outPort_q, outPort_d;
    logic             irq_q, irq_d;

    logic wr, ctrlWr, timerStart, timerAbort, timerBusy, timerDone;
    logic unusedWriteBits;

    assign wr              = chipselect & ~write_n;
    assign ctrlWr          = wr && (address == ADDR_CTRL);
    assign timerStart      = ctrlWr && writedata[CTRL_START];
    assign timerAbort      = ctrlWr && writedata[CTRL_ABORT];
    assign unusedWriteBits = ^writedata;

    system_alarm_pulse_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .start_i      (timerStart),
        .abort_i      (timerAbort),
        .len_i        (pulseLen_q),
        .busy_o       (timerBusy),
        .done_pulse_o (timerDone)
    );

    // Register file updates; a completion in the same cycle as DONE_CLR keeps DONE set.
    always_comb begin
        data_d      = data_q;
        pulseMask_d = pulseMask_q;
        pulseLen_d  = pulseLen_q;
        irqEn_d     = irqEn_q;
        done_d      = done_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d      = writedata[WIDTH-1:0];
                ADDR_PMASK:    pulseMask_d = writedata[WIDTH-1:0];
                ADDR_PLEN:     pulseLen_d  = writedata[CNT_W-1:0];
                ADDR_CTRL: begin
                    irqEn_d = writedata[CTRL_IRQ_EN];
                    if (writedata[CTRL_DONE_CLR]) begin
                        done_d = 1'b0;
                    end
                end
                ADDR_OUTSET:   data_d = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_d = data_q & ~writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        if (timerDone) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        readData_d = '0;
        case (address)
            ADDR_DATA:  readData_d = 32'(data_q);
            ADDR_PMASK: readData_d = 32'(pulseMask_q);
            ADDR_PLEN:  readData_d = 32'(pulseLen_q);
            ADDR_CTRL: begin
                readData_d[CTRL_BUSY]   = timerBusy;
                readData_d[CTRL_DONE]   = done_q;
                readData_d[CTRL_IRQ_EN] = irqEn_q;
            end
            default: ;
        endcase
        outPort_d = data_q | (timerBusy ? pulseMask_q : '0);
        irq_d     = done_d & irqEn_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q      <= RESET_VALUE;
            pulseMask_q <= '0;
            pulseLen_q  <= '0;
            irqEn_q     <= 1'b0;
            done_q      <= 1'b0;
            readData_q  <= '0;
            outPort_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            pulseMask_q <= pulseMask_d;
            pulseLen_q  <= pulseLen_d;
            irqEn_q     <= irqEn_d;
            done_q      <= done_d;
            readData_q  <= readData_d;
            outPort_q   <= outPort_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = readData_q;
    assign out_port = outPort_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_system_alarm_pulse_pio.sv
// Self-checking bench for system_alarm_pulse_pio: directed scenarios followed by
// random bus traffic, all checked against a time-based reference model.
module tb_system_alarm_pulse_pio;

    localparam logic [7:0] RV = 8'h5A;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    int pulseCount  = 0;

    // Model: the pulse is "busy after edge k" whenever k < pEnd
    logic [7:0]  mData, mPmask;
    logic [23:0] mPlen;
    logic        mIrqen, mDone;
    int          edgeNo = 0;
    int          pEnd   = 0;
    logic [31:0] expRd;
    logic [7:0]  expOut;
    logic        expIrq;

    system_alarm_pulse_pio #(
        .WIDTH       (8),
        .CNT_W       (24),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edgeNo);
        end
    endtask

    task automatic modelEdge(input logic r, input logic c, input logic w,
                             input logic [2:0] a, input logic [31:0] d);
        logic busyPre, wr, startEff, abortEff, completion, newDone;
        busyPre = (edgeNo <= pEnd);
        if (r) begin
            mData = RV; mPmask = '0; mPlen = '0; mIrqen = 1'b0; mDone = 1'b0;
            pEnd = edgeNo;
            expOut = '0; expRd = '0; expIrq = 1'b0;
            return;
        end
        expOut = mData | (busyPre ? mPmask : 8'h00);
        case (a)
            3'd0:    expRd = {24'h0, mData};
            3'd1:    expRd = {24'h0, mPmask};
            3'd2:    expRd = {8'h0, mPlen};
            3'd3:    expRd = {28'h0, mIrqen, 1'b0, mDone, busyPre};
            default: expRd = '0;
        endcase
        wr         = c & ~w;
        abortEff   = wr && (a == 3'd3) && d[1];
        startEff   = wr && (a == 3'd3) && d[0] && !d[1] && (mPlen != 0);
        completion = busyPre && (edgeNo == pEnd) && !abortEff && !startEff;
        newDone    = mDone;
        if (wr) begin
            case (a)
                3'd0: mData  = d[7:0];
                3'd1: mPmask = d[7:0];
                3'd2: mPlen  = d[23:0];
                3'd3: begin
                    mIrqen = d[3];
                    if (d[2]) newDone = 1'b0;
                end
                3'd4: mData = mData | d[7:0];
                3'd5: mData = mData & ~d[7:0];
                default: ;
            endcase
        end
        if (abortEff) pEnd = edgeNo;
        else if (startEff) pEnd = edgeNo + int'(mPlen);
        if (completion) newDone = 1'b1;
        mDone  = newDone;
        expIrq = mDone & mIrqen;
    endtask

    task automatic checkOutput();
        checkVal("out_port", 32'(out_port), 32'(expOut));
        checkVal("readdata", readdata, expRd);
        checkVal("irq", 32'(irq), 32'(expIrq));
        if (out_port[7]) pulseCount++;
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [2:0] a, input logic [31:0] d);
        reset = r; chipselect = c; write_n = w; address = a; writedata = d;
        @(posedge clk);
        #1;
        edgeNo++;
        modelEdge(r, c, w, a, d);
        checkOutput();
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic busRead(input logic [2:0] a);
        applyStimulus(1'b0, 1'b0, 1'b1, a, 32'h0);
    endtask

    initial begin
        logic        rr, rc, rw;
        logic [2:0]  ra;
        logic [31:0] rd;

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        #2;

        // Reset and reset value of DATA
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        checkVal("rst_out_port", 32'(out_port), 32'h0);
        checkVal("rst_readdata", readdata, 32'h0);
        busRead(3'd0);
        checkVal("rst_data_value", readdata, 32'(RV));

        // Data register with atomic set/clear
        busWrite(3'd0, 32'h0000_00A5);
        busWrite(3'd4, 32'h0000_000A);
        busWrite(3'd5, 32'h0000_0081);
        busRead(3'd0);
        checkVal("setclr_out_port", 32'(out_port), 32'h2E);
        checkVal("setclr_readback", readdata, 32'h2E);

        // Basic pulse with interrupt
        busWrite(3'd1, 32'h80);
        busWrite(3'd2, 32'd5);
        pulseCount = 0;
        busWrite(3'd3, 32'h9);
        for (int i = 0; i < 8; i++) busRead(3'd3);
        checkVal("pulse5_width", 32'(pulseCount), 32'd5);
        checkVal("pulse5_irq", 32'(irq), 32'h1);
        checkVal("pulse5_ctrl", readdata, 32'h0A);
        busWrite(3'd3, 32'h4);
        checkVal("doneclr_irq", 32'(irq), 32'h0);

        // Retrigger extends the pulse
        busWrite(3'd2, 32'd10);
        pulseCount = 0;
        busWrite(3'd3, 32'h1);
        for (int i = 0; i < 3; i++) busRead(3'd3);
        busWrite(3'd3, 32'h1);
        for (int i = 0; i < 16; i++) busRead(3'd3);
        checkVal("retrigger_width", 32'(pulseCount), 32'd14);

        // Abort wins over start and leaves DONE alone
        busWrite(3'd3, 32'h4);
        busWrite(3'd3, 32'h1);
        for (int i = 0; i < 3; i++) busRead(3'd3);
        busWrite(3'd3, 32'h3);
        busRead(3'd3);
        busRead(3'd3);
        checkVal("abort_ctrl", readdata, 32'h0);

        // Zero length start, then DONE_CLR colliding with completion
        busWrite(3'd2, 32'd0);
        busWrite(3'd3, 32'h1);
        busRead(3'd3);
        busRead(3'd3);
        checkVal("zero_len_ctrl", readdata, 32'h0);
        busWrite(3'd2, 32'd3);
        busWrite(3'd3, 32'h1);
        busRead(3'd3);
        busRead(3'd3);
        busWrite(3'd3, 32'h4);
        busRead(3'd3);
        busRead(3'd3);
        checkVal("done_set_wins", readdata, 32'h2);

        // Reset mid-pulse and reserved addresses
        busWrite(3'd2, 32'd6);
        busWrite(3'd3, 32'h1);
        busRead(3'd3);
        busRead(3'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 32'h0);
        checkVal("midreset_out_port", 32'(out_port), 32'h0);
        busRead(3'd3);
        busRead(3'd3);
        checkVal("midreset_busy", readdata, 32'h0);
        busWrite(3'd6, 32'hFFFF_FFFF);
        busWrite(3'd7, 32'hFFFF_FFFF);
        busRead(3'd6);
        checkVal("reserved6", readdata, 32'h0);
        busRead(3'd7);
        checkVal("reserved7", readdata, 32'h0);

        // Random bus traffic against the model
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 63) == 0);
            rc = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 2) == 0);
            ra = 3'($urandom_range(0, 7));
            rd = $urandom;
            if (ra == 3'd2) rd = 32'($urandom_range(0, 12));
            applyStimulus(rr, rc, rw, ra, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
